// File: rtl/base_tag_alloc.sv
// base_tag_alloc: free-bitmap tag allocator presenting the lowest free tag.
// Define BASE_TAG_ALLOC_CHK_EN to build the sticky protocol error check.
module base_tag_alloc #(
  parameter int a_width    = 2,
  parameter int depth      = 1 << a_width,
  parameter int free_ports = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic                          o_alloc_v,
  output logic [a_width-1:0]            o_alloc_a,
  input  logic                          i_alloc_take,
  input  logic [free_ports-1:0]         i_free_v,
  input  logic [a_width*free_ports-1:0] i_free_a,
  output logic [a_width:0]              o_free_cnt,
  output logic                          o_err
);

  logic [depth-1:0]   fbits;
  logic [depth-1:0]   fbits_in;
  logic [depth-1:0]   take_dec;
  logic [depth-1:0]   free_dec;
  logic [depth-1:0]   pdec [free_ports];
  logic               take;
  logic               alloc_v;
  logic [a_width-1:0] alloc_a;
  logic [a_width:0]   free_cnt;
  logic               alloc_v_nxt;
  logic [a_width-1:0] alloc_a_nxt;
  logic [a_width:0]   free_cnt_nxt;

  assign take = i_alloc_take & alloc_v;

  always_comb begin
    take_dec = '0;
    for (int i = 0; i < depth; i++) begin
      if (take && (alloc_a == a_width'(i))) begin
        take_dec[i] = 1'b1;
      end
    end
  end

  // Out-of-range indices decode to nothing, so they are dropped here.
  always_comb begin
    for (int j = 0; j < free_ports; j++) begin
      pdec[j] = '0;
      for (int i = 0; i < depth; i++) begin
        if (i_free_v[j] &&
            (i_free_a[j*a_width +: a_width] == a_width'(i))) begin
          pdec[j][i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    free_dec = '0;
    for (int j = 0; j < free_ports; j++) begin
      free_dec = free_dec | pdec[j];
    end
  end

  assign fbits_in = (fbits & ~take_dec) | free_dec;

  always_comb begin
    alloc_v_nxt  = |fbits_in;
    alloc_a_nxt  = '0;
    free_cnt_nxt = '0;
    for (int i = depth - 1; i >= 0; i--) begin
      if (fbits_in[i]) begin
        alloc_a_nxt = a_width'(i);
      end
    end
    for (int i = 0; i < depth; i++) begin
      free_cnt_nxt = free_cnt_nxt + {{a_width{1'b0}}, fbits_in[i]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fbits    <= '1;
      alloc_v  <= 1'b1;
      alloc_a  <= '0;
      free_cnt <= (a_width+1)'(depth);
    end else begin
      fbits    <= fbits_in;
      alloc_v  <= alloc_v_nxt;
      alloc_a  <= alloc_a_nxt;
      free_cnt <= free_cnt_nxt;
    end
  end

  assign o_alloc_v  = alloc_v;
  assign o_alloc_a  = alloc_a;
  assign o_free_cnt = free_cnt;

`ifdef BASE_TAG_ALLOC_CHK_EN
  logic err_q;
  logic err_hit;

  // Double free, free of the tag being taken, or two ports on one tag.
  always_comb begin
    err_hit = 1'b0;
    for (int j = 0; j < free_ports; j++) begin
      if (|(pdec[j] & fbits)) begin
        err_hit = 1'b1;
      end
      if (|(pdec[j] & take_dec)) begin
        err_hit = 1'b1;
      end
      for (int k = j + 1; k < free_ports; k++) begin
        if (|(pdec[j] & pdec[k])) begin
          err_hit = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (err_hit) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_base_tag_alloc.sv
// tb_base_tag_alloc: vector table, corner sequences and randomized
// traffic against a set-based allocator model.
module tb_base_tag_alloc;
  localparam int AW  = 2;
  localparam int DEP = 4;
  localparam int FP  = 2;
`ifdef BASE_TAG_ALLOC_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          o_alloc_v;
  logic [AW-1:0] o_alloc_a;
  logic          i_alloc_take = 1'b0;
  logic [FP-1:0] i_free_v = '0;
  logic [AW*FP-1:0] i_free_a = '0;
  logic [AW:0]   o_free_cnt;
  logic          o_err;

  int checks = 0;
  int errors = 0;

  bit mfree[DEP];
  bit merr;

  always #5 clk = ~clk;

  base_tag_alloc #(
    .a_width(AW), .depth(DEP), .free_ports(FP)
  ) dut (
    .clk(clk), .reset(reset),
    .o_alloc_v(o_alloc_v), .o_alloc_a(o_alloc_a),
    .i_alloc_take(i_alloc_take),
    .i_free_v(i_free_v), .i_free_a(i_free_a),
    .o_free_cnt(o_free_cnt), .o_err(o_err)
  );

  typedef struct {
    bit       tk;
    bit [1:0] fv;
    bit [1:0] fa0;
    bit [1:0] fa1;
    bit       ev;
    int       ea;
    int       ec;
    bit       ee;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int m_cnt();
    int c = 0;
    foreach (mfree[i]) c += int'(mfree[i]);
    return c;
  endfunction

  function automatic int m_low();
    foreach (mfree[i]) if (mfree[i]) return i;
    return 0;
  endfunction

  // Set semantics: remove the presented tag if taken, add freed tags.
  task automatic m_step(input bit tk, input bit [1:0] fv,
                        input int fa0, input int fa1);
    int fa[2];
    bit nf[DEP];
    bit eff;
    bit e;
    int p;
    fa[0] = fa0;
    fa[1] = fa1;
    nf = mfree;
    p = m_low();
    eff = tk && (m_cnt() > 0);
    e = 1'b0;
    if (eff) nf[p] = 1'b0;
    for (int j = 0; j < 2; j++) begin
      if (fv[j] && fa[j] < DEP) begin
        if (mfree[fa[j]]) e = 1'b1;
        if (eff && fa[j] == p) e = 1'b1;
        nf[fa[j]] = 1'b1;
      end
    end
    if (fv == 2'b11 && fa0 == fa1 && fa0 < DEP) e = 1'b1;
    if (CHK && e) merr = 1'b1;
    mfree = nf;
  endtask

  task automatic step(input bit tk, input bit [1:0] fv,
                      input bit [1:0] fa0, input bit [1:0] fa1);
    i_alloc_take = tk;
    i_free_v = fv;
    i_free_a = {fa1, fa0};
    m_step(tk, fv, int'(fa0), int'(fa1));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_alloc_take = 1'b0;
    i_free_v = '0;
    i_free_a = '0;
    reset = 1'b0;
    #2;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    foreach (mfree[i]) mfree[i] = 1'b1;
    merr = 1'b0;
  endtask

  task automatic chk_model(input string nm);
    chk({nm, ".v"}, int'(o_alloc_v), int'(m_cnt() > 0));
    if (m_cnt() > 0) chk({nm, ".a"}, int'(o_alloc_a), m_low());
    chk({nm, ".cnt"}, int'(o_free_cnt), m_cnt());
    chk({nm, ".err"}, int'(o_err), int'(merr));
  endtask

  initial begin
    tbl[0]  = '{1'b1, 2'b00, 2'd0, 2'd0, 1'b1, 1, 3, 1'b0};
    tbl[1]  = '{1'b1, 2'b00, 2'd0, 2'd0, 1'b1, 2, 2, 1'b0};
    tbl[2]  = '{1'b1, 2'b00, 2'd0, 2'd0, 1'b1, 3, 1, 1'b0};
    tbl[3]  = '{1'b1, 2'b00, 2'd0, 2'd0, 1'b0, 0, 0, 1'b0};
    tbl[4]  = '{1'b1, 2'b00, 2'd0, 2'd0, 1'b0, 0, 0, 1'b0};
    tbl[5]  = '{1'b0, 2'b01, 2'd2, 2'd0, 1'b1, 2, 1, 1'b0};
    tbl[6]  = '{1'b1, 2'b00, 2'd0, 2'd0, 1'b0, 0, 0, 1'b0};
    tbl[7]  = '{1'b0, 2'b11, 2'd3, 2'd1, 1'b1, 1, 2, 1'b0};
    tbl[8]  = '{1'b1, 2'b00, 2'd0, 2'd0, 1'b1, 3, 1, 1'b0};
    tbl[9]  = '{1'b1, 2'b00, 2'd0, 2'd0, 1'b0, 0, 0, 1'b0};
    tbl[10] = '{1'b0, 2'b11, 2'd0, 2'd0, 1'b1, 0, 1, 1'b1};
    tbl[11] = '{1'b1, 2'b01, 2'd0, 2'd0, 1'b1, 0, 1, 1'b1};

    #1;
    do_reset();
    chk("rst.v", int'(o_alloc_v), 1);
    chk("rst.a", int'(o_alloc_a), 0);
    chk("rst.cnt", int'(o_free_cnt), DEP);
    chk("rst.err", int'(o_err), 0);

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].tk, tbl[i].fv, tbl[i].fa0, tbl[i].fa1);
      chk($sformatf("tbl%0d.v", i), int'(o_alloc_v), int'(tbl[i].ev));
      if (tbl[i].ev)
        chk($sformatf("tbl%0d.a", i), int'(o_alloc_a), tbl[i].ea);
      chk($sformatf("tbl%0d.cnt", i), int'(o_free_cnt), tbl[i].ec);
      chk($sformatf("tbl%0d.err", i), int'(o_err),
          int'(CHK & tbl[i].ee));
    end

    // Double free of an idle tag leaves the bitmap untouched.
    do_reset();
    step(1'b1, 2'b00, 2'd0, 2'd0);
    step(1'b1, 2'b00, 2'd0, 2'd0);
    step(1'b0, 2'b01, 2'd2, 2'd0);
    chk("dbl.cnt", int'(o_free_cnt), 2);
    chk("dbl.a", int'(o_alloc_a), 2);
    chk("dbl.err", int'(o_err), int'(CHK));
    step(1'b0, 2'b00, 2'd0, 2'd0);
    chk("dbl.sticky", int'(o_err), int'(CHK));

    // Asynchronous reset in the middle of a cycle.
    do_reset();
    step(1'b1, 2'b01, 2'd3, 2'd0);
    step(1'b1, 2'b00, 2'd0, 2'd0);
    step(1'b1, 2'b00, 2'd0, 2'd0);
    i_alloc_take = 1'b0;
    i_free_v = '0;
    chk("pre.cnt", int'(o_free_cnt), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst.v", int'(o_alloc_v), 1);
    chk("arst.a", int'(o_alloc_a), 0);
    chk("arst.cnt", int'(o_free_cnt), DEP);
    chk("arst.err", int'(o_err), 0);
    do_reset();

    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int c = 0; c < 100; c++) begin
        bit tk;
        bit [1:0] fv;
        tk = ($urandom_range(0, 2) != 0);
        fv[0] = ($urandom_range(0, 3) == 0);
        fv[1] = ($urandom_range(0, 3) == 0);
        step(tk, fv, 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)));
        chk_model($sformatf("rnd%0d_%0d", r, c));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/base_tag_alloc.md
# base_tag_alloc

Free-list tag allocator for entries tracked by a valid-bit memory. It keeps a bitmap of free tags and presents the lowest-numbered free tag on a registered valid/take handshake. Tags retire through one or more free ports and become allocatable again one cycle later. The allocator issues the indices that are later set valid in, and cleared from, the valid-bit array.

## Interface
Parameters:
- a_width, 2, tag width in bits
- depth, 1<<a_width, number of tags (≤ 1<<a_width)
- free_ports, 1, number of independent free ports

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- o_alloc_v  output  1  a free tag is presented
- o_alloc_a  output  a_width  presented tag (lowest free index)
- i_alloc_take  input  1  consumer takes presented tag this cycle
- i_free_v  input  free_ports  per-port free strobe
- i_free_a  input  a_width*free_ports  per-port tag to free; port j at bits [j*a_width:(j+1)*a_width-1]
- o_free_cnt  output  a_width+1  number of free tags
- o_err  output  1  sticky protocol error (see Configuration)

## Operation
- State: fbits[0:depth-1] (1 = free), plus output registers alloc_v, alloc_a, free_cnt.
- take = i_alloc_take & o_alloc_v. Take while o_alloc_v=0 is ignored.
- take_dec = one-hot of o_alloc_a gated by take. free_dec = OR across ports of the one-hot decode of each i_free_a gated by i_free_v.
- fbits_in = (fbits & ~take_dec) | free_dec. Free wins over take for the same tag.
- Output registers load every cycle from fbits_in:
  - alloc_v = |fbits_in
  - alloc_a = index of the lowest set bit of fbits_in
  - free_cnt = popcount(fbits_in)
- No tag is presented twice without an intervening free. A taken tag is cleared in the same cycle the next candidate is computed.
- Freeing an already-free tag: no state change.
- Multiple ports freeing the same tag in the same cycle: single free.
- Indices ≥ depth on a free port are ignored.

## Timing
- Reset (asserted low, async): fbits all ones; o_alloc_v=1, o_alloc_a=0, o_free_cnt=depth, o_err=0. A tag is available in the first cycle after deassertion.
- Take in cycle N: the next tag appears in N+1. Back-to-back takes every cycle are supported, giving 1 tag/cycle until empty.
- Free in cycle N: the tag is counted in o_free_cnt and allocatable in N+1.
- Empty: o_alloc_v=0 and o_free_cnt=0 from the cycle after the last take. A free in cycle N restores o_alloc_v=1 in N+1.
- Reset asserted mid-operation returns all state to reset values immediately. Outstanding tags are forgotten.

## Configuration
- BASE_TAG_ALLOC_CHK_EN defined: o_err sets and stays set until reset on any of the following:
  - a free of a tag already free in fbits
  - a free of the tag being taken in the same cycle
  - two ports freeing the same tag in the same cycle
  The error is registered, so o_err rises the cycle after the offending event.
- Not defined: o_err is tied to 0 and no check logic is built. All other behaviour is identical.

## Test plan
(depth=4, free_ports=2 unless noted)
- Reset release, hold i_alloc_take=1 for 5 cycles -> o_alloc_a 0,1,2,3 on successive cycles, then o_alloc_v=0 and o_free_cnt=0.
- Empty; free tag 2 on port 0 in cycle N -> cycle N+1: o_alloc_v=1, o_alloc_a=2, o_free_cnt=1.
- All taken; same cycle free tags 3 (port 0) and 1 (port 1) -> next cycle: o_alloc_a=1, o_free_cnt=2; take -> o_alloc_a=3.
- Presented tag 0, take and free tag 0 in the same cycle -> tag 0 stays free, o_alloc_a=0 next cycle, o_free_cnt unchanged. With BASE_TAG_ALLOC_CHK_EN, o_err=1 the following cycle.
- Take tags 0 and 1, free tag 2 (already free) -> no state change, o_free_cnt=2. With BASE_TAG_ALLOC_CHK_EN, o_err=1; without it, o_err=0.
- Take tags 0–2, assert reset mid-cycle -> immediately o_alloc_v=1, o_alloc_a=0, o_free_cnt=4, o_err=0.
